shift_register_param: RTL and testbench

//  Parametrised universal shift register with serial input, word-complete flag and serial output.

---
 rtl/shift_register_param_pkg.sv | 16 +
 rtl/shift_register_param_word_counter.sv | 39 +++
 rtl/shift_register_param.sv | 69 ++++++
 tb/tb_shift_register_param.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_register_param_pkg.sv
// Shared mode encodings and sizing helpers for the universal shift register.
package shift_register_param_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_LOAD = 2'b11
    } shift_mode_e;

    // Bits needed to hold a shift count of 0..width.
    function automatic int count_bits(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_register_param_word_counter.sv
// Word counter: counts shifts and raises a one-cycle wrap pulse every WIDTH shifts.
module shift_word_counter
    import shift_register_param_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic wrap
);

    localparam int CNT_W = count_bits(WIDTH);

    logic [CNT_W-1:0] cnt;

    // A parallel load restarts the word; any cycle without a shift drops the pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (inc) begin
            if (cnt == CNT_W'(WIDTH - 1)) begin
                cnt  <= '0;
                wrap <= 1'b1;
            end else begin
                cnt  <= cnt + CNT_W'(1);
                wrap <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: rtl/shift_register_param.sv
// Parametrised universal shift register (hold / shift left / shift right / load).
// Optional parity output enabled by defining SHIFT_PARITY_EN.
module shift_register_param
    import shift_register_param_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             d_in,
    input  logic [WIDTH-1:0] p_in,
    output logic [WIDTH-1:0] out,
    output logic             serial_out,
    output logic             word_valid
`ifdef SHIFT_PARITY_EN
    ,
    output logic             parity
`endif
);

    shift_mode_e mode_sel;
    logic        cnt_inc;
    logic        cnt_clr;

    always_comb begin
        mode_sel = shift_mode_e'(mode);
        cnt_inc  = en && (mode_sel == MODE_SHL || mode_sel == MODE_SHR);
        cnt_clr  = en && (mode_sel == MODE_LOAD);
    end

    // serial_out only moves on a shift so it always shows the last bit that left.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out        <= RESET_VAL;
            serial_out <= 1'b0;
        end else if (en) begin
            case (mode_sel)
                MODE_SHL: begin
                    out        <= {out[WIDTH-2:0], d_in};
                    serial_out <= out[WIDTH-1];
                end
                MODE_SHR: begin
                    out        <= {d_in, out[WIDTH-1:1]};
                    serial_out <= out[0];
                end
                MODE_LOAD: out <= p_in;
                default: ;
            endcase
        end
    end

    shift_word_counter #(
        .WIDTH (WIDTH)
    ) u_word_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .wrap  (word_valid)
    );

`ifdef SHIFT_PARITY_EN
    assign parity = ^out;
`endif

endmodule

// File: tb/tb_shift_register_param.sv
// Directed self-checking bench for shift_register_param (WIDTH=4, RESET_VAL=0).
module tb_shift_register_param;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             en;
    logic [1:0]       mode;
    logic             d_in;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] out;
    logic             serial_out;
    logic             word_valid;
`ifdef SHIFT_PARITY_EN
    logic             parity;
`endif

    int pass_count  = 0;
    int check_count = 0;

    shift_register_param #(
        .WIDTH     (WIDTH),
        .RESET_VAL (4'b0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .d_in       (d_in),
        .p_in       (p_in),
        .out        (out),
        .serial_out (serial_out),
        .word_valid (word_valid)
`ifdef SHIFT_PARITY_EN
        ,
        .parity     (parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            check_count++;
            if (out !== 4'b0000 || word_valid !== 1'b0 || serial_out !== 1'b0)
                $display("[TB] FAIL reset_hold[%0d]: out=%b wv=%b so=%b, expected out=0000 wv=0 so=0",
                         i, out, word_valid, serial_out);
            else
                pass_count++;
        end
`ifdef SHIFT_PARITY_EN
        check_count++;
        if (parity !== 1'b0)
            $display("[TB] FAIL reset_parity: parity=%b, expected 0", parity);
        else
            pass_count++;
`endif
        mode = 2'b00;
        #2 reset = 1'b1;
        step();
        check_count++;
        if (out !== 4'b0000 || word_valid !== 1'b0)
            $display("[TB] FAIL reset_release: out=%b wv=%b, expected out=0000 wv=0", out, word_valid);
        else
            pass_count++;
    endtask

    task automatic test_shift_left();
        logic [3:0] bits_in [4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [3:0] exp_out [4]  = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
        logic       exp_wv  [4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
        mode = 2'b01;
        for (int i = 0; i < 4; i++) begin
            d_in = bits_in[i][0];
            step();
            check_count++;
            if (out !== exp_out[i] || word_valid !== exp_wv[i])
                $display("[TB] FAIL shl[%0d]: out=%b wv=%b, expected out=%b wv=%b",
                         i, out, word_valid, exp_out[i], exp_wv[i]);
            else
                pass_count++;
        end
        mode = 2'b00;
        step();
        check_count++;
        if (out !== 4'b1011 || word_valid !== 1'b0)
            $display("[TB] FAIL shl_hold: out=%b wv=%b, expected out=1011 wv=0", out, word_valid);
        else
            pass_count++;
    endtask

    task automatic test_load_shift_right();
        logic       exp_so  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] exp_out [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b0000};
        logic       exp_wv  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        mode = 2'b11;
        p_in = 4'b1001;
        step();
        check_count++;
        if (out !== 4'b1001 || word_valid !== 1'b0)
            $display("[TB] FAIL load: out=%b wv=%b, expected out=1001 wv=0", out, word_valid);
        else
            pass_count++;
        mode = 2'b10;
        d_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_count++;
            if (serial_out !== exp_so[i] || out !== exp_out[i] || word_valid !== exp_wv[i])
                $display("[TB] FAIL shr[%0d]: so=%b out=%b wv=%b, expected so=%b out=%b wv=%b",
                         i, serial_out, out, word_valid, exp_so[i], exp_out[i], exp_wv[i]);
            else
                pass_count++;
        end
    endtask

    task automatic test_reset_mid_word();
        logic [3:0] exp_out [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        logic       exp_wv  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        mode = 2'b01;
        d_in = 1'b1;
        step();
        step();
        #2 reset = 1'b0;
        #1;
        check_count++;
        if (out !== 4'b0000 || word_valid !== 1'b0)
            $display("[TB] FAIL mid_reset: out=%b wv=%b, expected out=0000 wv=0", out, word_valid);
        else
            pass_count++;
        #2 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_count++;
            if (out !== exp_out[i] || word_valid !== exp_wv[i])
                $display("[TB] FAIL post_reset[%0d]: out=%b wv=%b, expected out=%b wv=%b",
                         i, out, word_valid, exp_out[i], exp_wv[i]);
            else
                pass_count++;
        end
    endtask

    task automatic test_enable_hold();
        logic [3:0] exp_out [4] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
        logic       exp_wv  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        en   = 1'b0;
        mode = 2'b01;
        for (int i = 0; i < 3; i++) begin
            d_in = i[0];
            step();
            check_count++;
            if (out !== 4'b1111 || word_valid !== 1'b0)
                $display("[TB] FAIL en_hold[%0d]: out=%b wv=%b, expected out=1111 wv=0",
                         i, out, word_valid);
            else
                pass_count++;
        end
        // A full word after re-enabling proves the count did not advance while disabled.
        en   = 1'b1;
        d_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_count++;
            if (out !== exp_out[i] || word_valid !== exp_wv[i])
                $display("[TB] FAIL en_resume[%0d]: out=%b wv=%b, expected out=%b wv=%b",
                         i, out, word_valid, exp_out[i], exp_wv[i]);
            else
                pass_count++;
        end
    endtask

    task automatic test_direction_change();
        logic [1:0] modes   [4] = '{2'b01, 2'b01, 2'b10, 2'b10};
        logic       bits_in [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] exp_out [4] = '{4'b0001, 4'b0011, 4'b0001, 4'b0000};
        logic       exp_so  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       exp_wv  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            mode = modes[i];
            d_in = bits_in[i];
            step();
            check_count++;
            if (out !== exp_out[i] || serial_out !== exp_so[i] || word_valid !== exp_wv[i])
                $display("[TB] FAIL dir_change[%0d]: out=%b so=%b wv=%b, expected out=%b so=%b wv=%b",
                         i, out, serial_out, word_valid, exp_out[i], exp_so[i], exp_wv[i]);
            else
                pass_count++;
        end
    endtask

    task automatic test_back_to_back();
        logic exp_wv;
        mode = 2'b01;
        d_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_wv = (i == 3 || i == 7);
            step();
            check_count++;
            if (word_valid !== exp_wv)
                $display("[TB] FAIL back_to_back[%0d]: wv=%b, expected %b", i, word_valid, exp_wv);
            else
                pass_count++;
        end
        check_count++;
        if (out !== 4'b1111)
            $display("[TB] FAIL back_to_back_out: out=%b, expected 1111", out);
        else
            pass_count++;
    endtask

`ifdef SHIFT_PARITY_EN
    task automatic test_parity();
        mode = 2'b11;
        p_in = 4'b0111;
        step();
        check_count++;
        if (out !== 4'b0111 || parity !== 1'b1)
            $display("[TB] FAIL parity_load: out=%b parity=%b, expected out=0111 parity=1", out, parity);
        else
            pass_count++;
        mode = 2'b01;
        d_in = 1'b1;
        step();
        check_count++;
        if (out !== 4'b1111 || parity !== 1'b0)
            $display("[TB] FAIL parity_shift: out=%b parity=%b, expected out=1111 parity=0", out, parity);
        else
            pass_count++;
    endtask
`endif

    initial begin
        reset = 1'b0;
        en    = 1'b1;
        mode  = 2'b01;
        d_in  = 1'b1;
        p_in  = 4'b0000;
        test_reset();
        test_shift_left();
        test_load_shift_right();
        test_reset_mid_word();
        test_enable_hold();
        test_direction_change();
        test_back_to_back();
`ifdef SHIFT_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
